led_fade_pwm: RTL and testbench

//   Downstream consumer of the rotary-encoder count. Takes the 8-bit dial value as a

---
 rtl/led_fade_pwm.sv | 79 +++++++
 tb/tb_led_fade_pwm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// Brightness fader with mute toggle and PWM LED drive; level slews one LSB per RAMP_DIV clks.
// Optional quadratic brightness curve when LED_FADE_GAMMA_EN is defined (linear duty otherwise).
module led_fade_pwm #(
    parameter int WIDTH    = 8,
    parameter int RAMP_DIV = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] target,
    input  logic             button_n,
    output logic             pwm_out,
    output logic [WIDTH-1:0] level,
    output logic             muted,
    output logic             busy
);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] LVL_ONE  = WIDTH'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MUTE = 1'b1
    } state_t;

    // muted is the registered mirror of state and serves as the FSM's observable state.
    state_t           state;
    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] eff_target;
    logic [WIDTH-1:0] duty;
    logic             button_q;
    logic             press;
    logic             tick;

`ifdef LED_FADE_GAMMA_EN
    logic [2*WIDTH-1:0] level_sq;
    assign level_sq = {{WIDTH{1'b0}}, level} * {{WIDTH{1'b0}}, level};
    assign duty     = level_sq[2*WIDTH-1:WIDTH];
`else
    assign duty = level;
`endif

    assign eff_target = (state == ST_MUTE) ? '0 : target;
    assign press      = button_q & ~button_n;
    assign tick       = (prescaler == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            muted     <= 1'b0;
            prescaler <= '0;
            pwm_cnt   <= '0;
            pwm_out   <= 1'b0;
            level     <= '0;
            busy      <= 1'b0;
            button_q  <= 1'b1;
        end else begin
            button_q  <= button_n;
            prescaler <= tick ? '0 : prescaler + PRE_ONE;
            pwm_cnt   <= pwm_cnt + LVL_ONE;
            pwm_out   <= (duty > pwm_cnt);
            busy      <= (level != eff_target);

            // A step on a press edge still uses the pre-toggle eff_target.
            if (tick) begin
                if (level < eff_target)
                    level <= level + LVL_ONE;
                else if (level > eff_target)
                    level <= level - LVL_ONE;
            end

            if (press) begin
                state <= (state == ST_RUN) ? ST_MUTE : ST_RUN;
                muted <= (state == ST_RUN);
            end
        end
    end
endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm (WIDTH=8, RAMP_DIV=4) with a cycle model and literal spot checks.
module tb_led_fade_pwm;
    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int PER = 1 << W;

    logic         clk;
    logic         rst;
    logic [W-1:0] target;
    logic         button_n;
    logic         pwm_out;
    logic [W-1:0] level;
    logic         muted;
    logic         busy;

    int tests = 0;
    int fails = 0;

    led_fade_pwm #(.WIDTH(W), .RAMP_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .target   (target),
        .button_n (button_n),
        .pwm_out  (pwm_out),
        .level    (level),
        .muted    (muted),
        .busy     (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: n = edges since reset; prescaler = n mod DIV, pwm counter = n mod 2**W
    function automatic int duty_of(input int lv);
`ifdef LED_FADE_GAMMA_EN
        return (lv * lv) / PER;
`else
        return lv;
`endif
    endfunction

    int m_level, n;
    bit m_muted, m_pwm, m_busy, m_btn_prev, m_valid;
    initial m_valid = 1'b0;

    always @(posedge clk) begin
        int eff;
        if (rst) begin
            m_level    <= 0;
            m_muted    <= 1'b0;
            m_pwm      <= 1'b0;
            m_busy     <= 1'b0;
            m_btn_prev <= 1'b1;
            n          <= 0;
            m_valid    <= 1'b1;
        end else begin
            eff = m_muted ? 0 : int'(target);
            m_busy <= (m_level != eff);
            m_pwm  <= (duty_of(m_level) > (n % PER));
            if ((n % DIV) == DIV - 1)
                m_level <= (m_level < eff) ? m_level + 1 : (m_level > eff) ? m_level - 1 : m_level;
            if (m_btn_prev && !button_n)
                m_muted <= !m_muted;
            m_btn_prev <= button_n;
            n <= n + 1;
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_level", level, m_level);
            check("cyc_muted", muted, m_muted);
            check("cyc_busy", busy, m_busy);
            check("cyc_pwm", pwm_out, m_pwm);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_settle(input int v, input string name);
        int k = 0;
        while (!(level == W'(v) && busy == 1'b0) && k < 3000) begin
            step();
            k++;
        end
        check(name, {level, 7'd0, busy}, {W'(v), 7'd0, 1'b0});
    endtask

    task automatic count_high(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (pwm_out) cnt++;
        end
    endtask

    initial begin
        int hi, k;
        logic prev;
        rst = 1'b1; target = 8'd3; button_n = 1'b1;
        repeat (2) step();
        check("rst_level", level, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_muted", muted, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // ramp 0->3: steps at edges 4, 8, 12 after release
        for (int e = 1; e <= 24; e++) begin
            step();
            if (e == 1)  check("t1_busy_e1", busy, 1);
            if (e == 3)  check("t1_level_e3", level, 0);
            if (e == 4)  check("t1_level_e4", level, 1);
            if (e == 8)  check("t1_level_e8", level, 2);
            if (e == 12) check("t1_level_e12", level, 3);
            if (e == 12) check("t1_busy_e12", busy, 1);
            if (e == 13) check("t1_busy_e13", busy, 0);
            if (e == 24) check("t1_hold", level, 3);
        end

        // PWM at duty 0 and mid scale
        target = 8'd0;
        wait_settle(0, "t2_settle0");
        count_high(512, hi);
        check("t2_duty0", hi, 0);
        target = 8'd128;
        wait_settle(128, "t2_settle128");
        for (int w = 0; w < 2; w++) begin
            count_high(PER, hi);
`ifdef LED_FADE_GAMMA_EN
            check("t6_duty128", hi, 64);
`else
            check("t2_duty128", hi, 128);
`endif
        end

        // mute by held button, then unmute
        target = 8'd10;
        wait_settle(10, "t3_settle10");
        button_n = 1'b0;
        step();
        check("t3_muted_on", muted, 1);
        repeat (19) step();
        check("t3_single_toggle", muted, 1);
        button_n = 1'b1;
        wait_settle(0, "t3_fade_out");
        check("t3_still_muted", muted, 1);
        button_n = 1'b0;
        step();
        check("t3_muted_off", muted, 0);
        repeat (4) step();
        button_n = 1'b1;
        wait_settle(10, "t3_fade_in");

        // target drop mid ramp
        target = 8'd200;
        k = 0;
        while (level != 8'd100 && k < 1000) begin step(); k++; end
        check("t4_reach100", level, 100);
        target = 8'd0;
        k = 0;
        while (level == 8'd100 && k < 8) begin step(); k++; end
        check("t4_step99", level, 99);
        k = 0;
        while (level == 8'd99 && k < 8) begin step(); k++; end
        check("t4_step98", level, 98);
        wait_settle(0, "t4_floor");
        repeat (8) step();
        check("t4_no_wrap", level, 0);
        check("t4_busy0", busy, 0);

        // reset while muted with pwm high
        target = 8'd57;
        wait_settle(57, "t5_settle57");
        prev = pwm_out;
        k = 0;
        while (!(prev == 1'b0 && pwm_out == 1'b1) && k < 600) begin
            prev = pwm_out;
            step();
            k++;
        end
        check("t5_pwm_rise", pwm_out, 1);
        button_n = 1'b0;
        step();
        check("t5_pre_muted", muted, 1);
        check("t5_pre_level", level, 57);
        check("t5_pre_pwm", pwm_out, 1);
        rst = 1'b1;
        button_n = 1'b1;
        step();
        check("t5_level", level, 0);
        check("t5_muted", muted, 0);
        check("t5_pwm", pwm_out, 0);
        check("t5_busy", busy, 0);
        rst = 1'b0;

        // full scale
        target = 8'd255;
        wait_settle(255, "t6_settle255");
        count_high(PER, hi);
`ifdef LED_FADE_GAMMA_EN
        check("t6_duty255", hi, 254);
`else
        check("t2_duty255", hi, 255);
`endif

        // encoder wrap 255->0 ramps full scale down
        target = 8'd0;
        repeat (8) step();
        check("t4_wrap_down", level, 253);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
